// File: rtl/ps2_key_serializer_pkg.sv
// +------------------------------------------------------------------+
// | pc8001m_ps2_pkg: shared constants, tx states and frame builder    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package pc8001m_ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam int         FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    BIT_HI = 3'd2,
    BIT_LO = 3'd3,
    GAP    = 3'd4
  } ps2_tx_state_t;

  // Frame is sent LSB first: start(0), data[7:0], odd parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_serializer_if.sv
// +------------------------------------------------------------------+
// | ps2_key_serializer_if: hps_io key event in, PS/2 stream out       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface ps2_key_serializer_if;
  logic [10:0] ps2_key;
  logic        ps2_clk;
  logic        ps2_data;
  logic        busy;
  logic        overflow;

  modport master (output ps2_key, input ps2_clk, ps2_data, busy, overflow);
  modport slave  (input ps2_key, output ps2_clk, ps2_data, busy, overflow);
endinterface

`default_nettype wire

// File: rtl/ps2_key_serializer_fifo.sv
// +------------------------------------------------------------------+
// | ps2_byte_fifo: byte FIFO taking up to three bytes per push cycle  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               wr_n,
  input  logic [7:0]               wr_data0,
  input  logic [7:0]               wr_data1,
  input  logic [7:0]               wr_data2,
  input  logic                     rd,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;

  assign pop      = rd & ~empty;
  assign empty    = (count == '0);
  assign free_cnt = CW'(DEPTH) - count;
  assign rd_data  = mem[rd_ptr];

  // Writer guarantees wr_n never exceeds free_cnt, so lanes never collide.
  always_ff @(posedge clk) begin
    if (wr_n >= 2'd1) mem[wr_ptr]          <= wr_data0;
    if (wr_n >= 2'd2) mem[wr_ptr + AW'(1)] <= wr_data1;
    if (wr_n == 2'd3) mem[wr_ptr + AW'(2)] <= wr_data2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_n);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(wr_n) - CW'(pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_serializer.sv
// +------------------------------------------------------------------+
// | ps2_key_serializer: hps_io ps2_key events -> PS/2 device stream   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module ps2_key_serializer
  import pc8001m_ps2_pkg::*;
#(
  parameter int CLK_DIV    = 1145,
  parameter int GAP_CYCLES = 2290,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk2,
  input  logic                 reset_n,
  ps2_key_serializer_if.slave  bus
);

  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic       tog_q, armed, ev_valid, ovf_q;
  logic [9:0] ev_key;
  logic       ext, brk, admit;
  logic [1:0] n_bytes, wr_n;
  logic [7:0] lane0, lane1, lane2, rd_data;
  logic [FW-1:0] free_cnt;
  logic       empty, pop;

  ps2_tx_state_t           state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [3:0]              idx, idx_nxt;
  logic [7:0]              byte_q, byte_nxt;
  logic [FRAME_BITS-1:0]   frame_q, frame_nxt;
  logic                    clk_q, data_q, clk_nxt, data_nxt;

  // First clock after reset only samples the toggle, so a stale level is not an event.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      armed    <= 1'b0;
      ev_valid <= 1'b0;
      ev_key   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      tog_q    <= bus.ps2_key[10];
      armed    <= 1'b1;
      ev_valid <= armed & (bus.ps2_key[10] != tog_q);
      ev_key   <= bus.ps2_key[9:0];
      ovf_q    <= ev_valid & ~admit;
    end
  end

  assign ext     = ev_key[8];
  assign brk     = ~ev_key[9];
  assign n_bytes = 2'd1 + {1'b0, ext} + {1'b0, brk};
  assign admit   = ev_valid & (free_cnt >= FW'(n_bytes));
  assign wr_n    = admit ? n_bytes : 2'd0;

  always_comb begin
    lane0 = ev_key[7:0];
    lane1 = 8'h00;
    lane2 = 8'h00;
    case ({ext, brk})
      2'b11: begin lane0 = PS2_EXT; lane1 = PS2_BRK; lane2 = ev_key[7:0]; end
      2'b10: begin lane0 = PS2_EXT; lane1 = ev_key[7:0]; end
      2'b01: begin lane0 = PS2_BRK; lane1 = ev_key[7:0]; end
      default: ;
    endcase
  end

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk2),
    .reset_n  (reset_n),
    .wr_n     (wr_n),
    .wr_data0 (lane0),
    .wr_data1 (lane1),
    .wr_data2 (lane2),
    .rd       (pop),
    .rd_data  (rd_data),
    .free_cnt (free_cnt),
    .empty    (empty)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - CW'(1);
    idx_nxt   = idx;
    byte_nxt  = byte_q;
    frame_nxt = frame_q;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        byte_nxt  = rd_data;
        state_nxt = LOAD;
      end
      LOAD: begin
        frame_nxt = build_frame(byte_q);
        idx_nxt   = 4'd0;
        state_nxt = BIT_HI;
      end
      BIT_HI: if (cnt == '0) state_nxt = BIT_LO;
      BIT_LO: if (cnt == '0) begin
        if (idx == 4'd10) begin
          state_nxt = GAP;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = BIT_HI;
        end
      end
      GAP: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Single counter, reloaded whenever a state is entered.
    if (state_nxt != state) begin
      case (state_nxt)
        BIT_HI, BIT_LO: cnt_nxt = CW'(CLK_DIV - 1);
        GAP:            cnt_nxt = CW'(GAP_CYCLES - 1);
        default:        cnt_nxt = '0;
      endcase
    end
    clk_nxt  = (state_nxt != BIT_LO);
    data_nxt = (state_nxt == BIT_HI || state_nxt == BIT_LO) ? frame_nxt[idx_nxt] : 1'b1;
  end

  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      byte_q  <= '0;
      frame_q <= '1;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      byte_q  <= byte_nxt;
      frame_q <= frame_nxt;
      clk_q   <= clk_nxt;
      data_q  <= data_nxt;
    end
  end

  assign bus.ps2_clk  = clk_q;
  assign bus.ps2_data = data_q;
  assign bus.busy     = (state != IDLE) | ~empty;
  assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_serializer.sv
// +------------------------------------------------------------------+
// | tb_ps2_key_serializer: directed bench with a PS/2 line receiver   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ps2_key_serializer;

  localparam int CLK_DIV = 4;

  logic clk2 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk2 = ~clk2;

  ps2_key_serializer_if bus ();

  ps2_key_serializer #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(8), .FIFO_DEPTH(8)) dut (
    .clk2    (clk2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Line receiver: samples on the falling clk2 edge, away from DUT updates.
  logic [10:0] rx_q[$];
  int          gap_q[$];
  logic [10:0] shreg;
  logic        prev_c = 1'b1;
  int run = 0, bitcnt = 0, cur_gap = 0;
  int fall_cnt = 0, lo_phases = 0, lo_bad = 0, hi_bad = 0, ovf_cnt = 0, busy_seen = 0;

  always @(negedge clk2) begin
    if (!reset_n) begin
      prev_c = 1'b1;
      run    = 0;
      bitcnt = 0;
    end else begin
      if (bus.ps2_clk == prev_c) begin
        run++;
      end else begin
        if (prev_c) begin
          fall_cnt++;
          if (bitcnt == 0) cur_gap = run;
          else if (run != CLK_DIV) hi_bad++;
          shreg[bitcnt] = bus.ps2_data;
          bitcnt++;
          if (bitcnt == 11) begin
            rx_q.push_back(shreg);
            gap_q.push_back(cur_gap);
            bitcnt = 0;
          end
        end else begin
          lo_phases++;
          if (run != CLK_DIV) lo_bad++;
        end
        run = 1;
      end
      prev_c = bus.ps2_clk;
      if (bus.overflow) ovf_cnt++;
      if (bus.busy) busy_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [10:0] exp, input int exp_gap);
    int t = 0;
    logic [10:0] f;
    int g;
    while (rx_q.size() == 0 && t < 400) begin
      @(negedge clk2);
      t++;
    end
    #2;
    check({tag, " present"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) begin
      f = rx_q.pop_front();
      g = gap_q.pop_front();
      check(tag, 32'(f), 32'(exp));
      if (exp_gap > 0) check({tag, " gap"}, g, exp_gap);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 2000) begin
      @(negedge clk2);
      t++;
    end
    check("idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_clk_low();
    int t = 0;
    while (bus.ps2_clk && t < 200) begin
      @(negedge clk2);
      t++;
    end
    check("clk_low", 32'(bus.ps2_clk), 32'd0);
  endtask

  logic tog = 1'b0;

  task automatic send_key(input logic pressed, input logic extended, input logic [7:0] code);
    @(negedge clk2);
    tog = ~tog;
    bus.ps2_key = {tog, pressed, extended, code};
  endtask

  initial begin
    int f0, b0, o0;
    bus.ps2_key = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk2);
    #1;
    check("rst clk", 32'(bus.ps2_clk), 32'd1);
    check("rst data", 32'(bus.ps2_data), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk2);
    reset_n = 1'b1;

    // 1: quiet input
    f0 = fall_cnt; b0 = busy_seen; o0 = ovf_cnt;
    repeat (100) @(negedge clk2);
    #2;
    check("quiet edges", fall_cnt - f0, 0);
    check("quiet busy", busy_seen - b0, 0);
    check("quiet ovf", ovf_cnt - o0, 0);

    // 2: press 'A', check start-bit latency
    send_key(1'b1, 1'b0, 8'h1C);
    @(posedge clk2); #1;
    check("lat N data", 32'(bus.ps2_data), 32'd1);
    @(posedge clk2); #1;
    check("lat N+1 busy", 32'(bus.busy), 32'd1);
    check("lat N+1 data", 32'(bus.ps2_data), 32'd1);
    @(posedge clk2); #1;
    check("lat N+2 data", 32'(bus.ps2_data), 32'd1);
    @(posedge clk2); #1;
    check("lat N+3 data", 32'(bus.ps2_data), 32'd0);
    check("lat N+3 clk", 32'(bus.ps2_clk), 32'd1);
    expect_frame("A 1C", 11'h438, 0);

    // 3: extended right-arrow release
    wait_idle();
    send_key(1'b0, 1'b1, 8'h74);
    expect_frame("rel E0", 11'h5C0, 0);
    expect_frame("rel F0", 11'h7E0, 14);
    expect_frame("rel 74", 11'h6E8, 14);

    // 4: overflow while first frame is in flight
    wait_idle();
    repeat (2) @(negedge clk2);
    send_key(1'b1, 1'b0, 8'h29);
    wait_clk_low();
    o0 = ovf_cnt;
    send_key(1'b0, 1'b1, 8'h74); repeat (2) @(negedge clk2);
    send_key(1'b0, 1'b1, 8'h6B); repeat (2) @(negedge clk2);
    send_key(1'b0, 1'b1, 8'h75); repeat (2) @(negedge clk2);
    send_key(1'b0, 1'b1, 8'h72); repeat (3) @(negedge clk2);
    #2;
    check("ovf pulses", ovf_cnt - o0, 2);
    expect_frame("ov 29", 11'h452, 0);
    expect_frame("ov E0a", 11'h5C0, 14);
    expect_frame("ov F0a", 11'h7E0, 14);
    expect_frame("ov 74", 11'h6E8, 14);
    expect_frame("ov E0b", 11'h5C0, 14);
    expect_frame("ov F0b", 11'h7E0, 14);
    expect_frame("ov 6B", 11'h4D6, 14);
    wait_idle();
    repeat (20) @(negedge clk2);
    #2;
    check("ov no extra", rx_q.size(), 0);

    // 5: asynchronous reset mid BIT_LO
    send_key(1'b1, 1'b0, 8'h1C);
    wait_clk_low();
    @(negedge clk2);
    #2 reset_n = 1'b0;
    #1;
    check("arst clk", 32'(bus.ps2_clk), 32'd1);
    check("arst data", 32'(bus.ps2_data), 32'd1);
    check("arst busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk2);
    reset_n = 1'b1;
    repeat (6) @(negedge clk2);
    #2;
    check("arst no frame", rx_q.size(), 0);
    check("arst idle", 32'(bus.busy), 32'd0);
    send_key(1'b1, 1'b0, 8'h5A);
    expect_frame("post 5A", 11'h6B4, 0);

    // 6: parity corners and phase timing
    wait_idle();
    send_key(1'b1, 1'b0, 8'hFF);
    expect_frame("par FF", 11'h7FE, 0);
    wait_idle();
    send_key(1'b1, 1'b0, 8'h00);
    expect_frame("par 00", 11'h600, 0);
    wait_idle();
    #2;
    check("lo phase len", lo_bad, 0);
    check("hi phase len", hi_bad, 0);
    check("lo phase cnt", lo_phases, 154);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
